// File: rtl/hebb_learner_array.sv
// hebb_learner_array: sequential Hebbian / anti-Hebbian update engine for the
// fan-in weights of one neuron. Weights are sign-magnitude {sign, mag} and are
// nudged by +/-STEP one per cycle during a learning pass.
module hebb_learner_array #(
  parameter int N     = 8,
  parameter int MAG_W = 8,
  parameter int STEP  = 1,
  localparam int AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     x,
  input  logic             x_in,
  input  logic             mode,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [MAG_W:0]   wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [MAG_W:0]   rd_data,
  output logic             busy,
  output logic             done
);

  localparam logic [MAG_W:0] STEP_V   = (MAG_W+1)'(STEP);
  localparam logic [MAG_W:0] MAX_V    = {1'b0, {MAG_W{1'b1}}};
  localparam logic [AW:0]    N_V      = (AW+1)'(N);
  localparam logic [AW-1:0]  IDX_LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [N-1:0]    x_q;
  logic            x_in_q;
  logic            mode_q;
  logic [MAG_W:0]  w [N];

  logic            dir_pos;
  logic            wr_ok;
  logic            rd_ok;
  logic [MAG_W:0]  wr_clean;

  // Move a sign-magnitude weight one STEP towards the requested direction.
  // Magnitudes are widened by one bit so the saturating add never wraps.
  function automatic logic [MAG_W:0] nudge(input logic [MAG_W:0] wv, input logic neg);
    logic [MAG_W:0] mag_e;
    logic [MAG_W:0] tmp;
    logic [MAG_W:0] res;
    mag_e = {1'b0, wv[MAG_W-1:0]};
    if ((wv[MAG_W] == neg) || (mag_e == '0)) begin
      tmp = mag_e + STEP_V;
      if (tmp > MAX_V) tmp = MAX_V;
      res = {neg, tmp[MAG_W-1:0]};
    end else if (mag_e > STEP_V) begin
      tmp = mag_e - STEP_V;
      res = {wv[MAG_W], tmp[MAG_W-1:0]};
    end else if (mag_e == STEP_V) begin
      res = '0;
    end else begin
      tmp = STEP_V - mag_e;
      res = {neg, tmp[MAG_W-1:0]};
    end
    return res;
  endfunction

  // Direction for the current weight, write sanitising and read mux.
  always_comb begin
    dir_pos  = (x_q[idx] == x_in_q) ^ mode_q;
    wr_ok    = ({1'b0, wr_addr} < N_V);
    rd_ok    = ({1'b0, rd_addr} < N_V);
    wr_clean = (wr_data[MAG_W-1:0] == '0) ? '0 : wr_data;
    rd_data  = rd_ok ? w[rd_addr] : '0;
  end

  // Pass controller and weight register file; host writes land before a
  // same-cycle start so the pass sees the freshly written value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      x_q    <= '0;
      x_in_q <= 1'b0;
      mode_q <= 1'b0;
      w      <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (wr_en && wr_ok) w[wr_addr] <= wr_clean;
          if (start) begin
            x_q    <= x;
            x_in_q <= x_in;
            mode_q <= mode;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          w[idx] <= nudge(w[idx], ~dir_pos);
          if (idx == IDX_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
